// File: rtl/eig_pkg.sv
// Shared definitions for the eigenvalue <-> characteristic polynomial blocks.
// The solver-side bench uses the same widths and state encoding, so keep
// this package free of anything specific to one side of the loopback.
package eig_pkg;

    localparam int EIG_W   = 16;   // eigenvalue component width, two's complement
    localparam int SQ_W    = 31;   // width of one square, |x|^2 <= 2^30
    localparam int DET_W   = 32;   // re^2 + im^2 <= 2^31
    localparam int TRACE_W = 17;   // 2*re

    typedef enum logic [2:0] {
        IDLE,
        MUL_RE,
        MUL_IM,
        SUM,
        DONE
    } state_t;

endpackage

// File: rtl/mul16_reg.sv
// Signed 16x16 multiplier with a single output register stage.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears the product register
//   en_i  - clock enable, low holds the registered product
//   a_i   - signed multiplicand
//   b_i   - signed multiplier
//   p_o   - registered signed product, valid one enabled cycle after a_i/b_i
module mul16_reg
    import eig_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [EIG_W-1:0] a_i,
    input  logic [EIG_W-1:0] b_i,
    output logic [DET_W-1:0] p_o
);

    logic [DET_W-1:0] prod_q;

    // Product register. Operands are sign-extended to the full 32-bit result
    // width before multiplying, so the full-scale corner (-32768)^2 is exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= $signed(a_i) * $signed(b_i);
        end
    end

    assign p_o = prod_q;

endmodule

// File: rtl/eig_to_charpoly.sv
// Rebuilds the 2x2 characteristic polynomial l^2 - T*l + D from a
// complex-conjugate eigenvalue pair re +/- j*im: T = 2*re, D = re^2 + im^2.
// One shared registered multiplier squares re, then im; the FSM sequences it.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   enable     - clock enable; low freezes FSM, registers and handshakes
//   in_valid / in_ready   - input handshake for eig_reel / eig_comp
//   eig_reel   - signed real part (16 bit)
//   eig_comp   - signed imaginary magnitude (16 bit, sign irrelevant)
//   out_valid / out_ready - output handshake for trace / det
//   trace      - signed 17-bit 2*re
//   det        - unsigned 32-bit re^2 + im^2
// Optional build macro COMPANION_OUT_EN adds companion matrix outputs
//   m11, m12, m22 (17-bit signed) and m21 (33-bit signed) = [[0,1],[-det,trace]].
module eig_to_charpoly
    import eig_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EIG_W-1:0]   eig_reel,
    input  logic [EIG_W-1:0]   eig_comp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TRACE_W-1:0] trace,
    output logic [DET_W-1:0]   det
`ifdef COMPANION_OUT_EN
    ,
    output logic [TRACE_W-1:0] m11,
    output logic [TRACE_W-1:0] m12,
    output logic [DET_W:0]     m21,
    output logic [TRACE_W-1:0] m22
`endif
);

    state_t             state_q, state_d;
    logic [EIG_W-1:0]   re_q, im_q;
    logic [SQ_W-1:0]    re2_q;
    logic [TRACE_W-1:0] trace_q;
    logic [DET_W-1:0]   det_q;
    logic [EIG_W-1:0]   mulA, mulB;
    logic [DET_W-1:0]   prod;
    logic [DET_W-1:0]   detSum;
    logic               accept, capRe, capDet;

    mul16_reg u_mul (
        .clk  (clk),
        .rst  (rst),
        .en_i (enable),
        .a_i  (mulA),
        .b_i  (mulB),
        .p_o  (prod)
    );

    // Squares are never negative, so bit 31 of the product is always zero and
    // the 32-bit sum of two 31-bit squares cannot overflow.
    assign detSum = {1'b0, re2_q} + prod;

    // Next-state and control decode. The multiplier output lags its operands
    // by one cycle: re^2 appears during MUL_IM and im^2 during SUM.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mulA      = '0;
        mulB      = '0;
        accept    = 1'b0;
        capRe     = 1'b0;
        capDet    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = MUL_RE;
                end
            end
            MUL_RE: begin
                mulA    = re_q;
                mulB    = re_q;
                state_d = MUL_IM;
            end
            MUL_IM: begin
                capRe   = 1'b1;
                mulA    = im_q;
                mulB    = im_q;
                state_d = SUM;
            end
            SUM: begin
                capDet  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; enable low holds the FSM so no handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Datapath registers. trace/det are only overwritten on accept/SUM, so
    // they remain readable after the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q    <= '0;
            im_q    <= '0;
            re2_q   <= '0;
            trace_q <= '0;
            det_q   <= '0;
        end else if (enable) begin
            if (accept) begin
                re_q    <= eig_reel;
                im_q    <= eig_comp;
                trace_q <= {eig_reel, 1'b0};
            end
            if (capRe) begin
                re2_q <= prod[SQ_W-1:0];
            end
            if (capDet) begin
                det_q <= detSum;
            end
        end
    end

    assign trace = trace_q;
    assign det   = det_q;

`ifdef COMPANION_OUT_EN
    logic          m12Set_q;
    logic [DET_W:0] m21_q;

    // Companion matrix terms update alongside trace (accept) and det (SUM).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m12Set_q <= 1'b0;
            m21_q    <= '0;
        end else if (enable) begin
            if (accept) begin
                m12Set_q <= 1'b1;
            end
            if (capDet) begin
                m21_q <= -{1'b0, detSum};
            end
        end
    end

    assign m11 = '0;
    assign m12 = {{(TRACE_W-1){1'b0}}, m12Set_q};
    assign m21 = m21_q;
    assign m22 = trace_q;
`endif

endmodule

// File: tb/tb_eig_to_charpoly.sv
// Directed bench for eig_to_charpoly. Stimulus pushes the hand-computed
// trace/det into a scoreboard; a monitor pops and compares on every output
// handshake, so ordering and dropped/extra results are caught as well.
module tb_eig_to_charpoly;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] eig_reel;
    logic [15:0] eig_comp;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] trace;
    logic [31:0] det;

    logic [16:0] expTraceQ[$];
    logic [31:0] expDetQ[$];
    int          checks = 0;
    int          errors = 0;

    eig_to_charpoly dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .eig_reel  (eig_reel),
        .eig_comp  (eig_comp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .trace     (trace),
        .det       (det)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one pair once in_ready is seen, optionally recording its result.
    task automatic applyStimulus(input logic [15:0] re, input logic [15:0] im,
                                 input logic [16:0] expTrace, input logic [31:0] expDet,
                                 input bit doPush);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("in_ready before offer", {63'd0, in_ready}, 64'd1);
        eig_reel = re;
        eig_comp = im;
        in_valid = 1'b1;
        if (doPush) begin
            expTraceQ.push_back(expTrace);
            expDetQ.push_back(expDet);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        eig_reel = 16'($urandom);
        eig_comp = 16'($urandom);
    endtask

    // Count enabled edges until out_valid shows, bounded.
    task automatic waitValid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            checkOutput("out_valid timeout", {63'd0, out_valid}, 64'd1);
            n = -1;
        end
    endtask

    // Scoreboard monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && enable === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expTraceQ.size() == 0) begin
                checkOutput("unexpected result", 64'd1, 64'd0);
            end else begin
                checkOutput("trace", {47'd0, trace}, {47'd0, expTraceQ.pop_front()});
                checkOutput("det", {32'd0, det}, {32'd0, expDetQ.pop_front()});
            end
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int total;

        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        eig_reel  = '0;
        eig_comp  = '0;
        #1;
        checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset trace", {47'd0, trace}, 64'd0);
        checkOutput("reset det", {32'd0, det}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 3 + j4: latency from accepting edge, single-cycle valid pulse
        applyStimulus(16'd3, 16'd4, 17'd6, 32'd25, 1'b1);
        checkOutput("in_ready busy", {63'd0, in_ready}, 64'd0);
        waitValid(n);
        checkOutput("latency 3+j4", 64'(n), 64'd3);
        @(posedge clk); #1;
        checkOutput("valid one pulse", {63'd0, out_valid}, 64'd0);
        checkOutput("in_ready after done", {63'd0, in_ready}, 64'd1);

        // Full-scale corner and small patterns, back to back
        applyStimulus(16'h8000, 16'h8000, 17'h10000, 32'h8000_0000, 1'b1);
        waitValid(n);
        applyStimulus(16'd0, 16'd0, 17'd0, 32'd0, 1'b1);
        waitValid(n);
        applyStimulus(16'hFFFB, 16'd0, 17'h1FFF6, 32'd25, 1'b1);
        waitValid(n);
        @(posedge clk); #1;

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        applyStimulus(16'd100, 16'hFF38, 17'd200, 32'd50000, 1'b1);
        waitValid(n);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("stall out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("stall trace", {47'd0, trace}, 64'd200);
            checkOutput("stall det", {32'd0, det}, 64'd50000);
            checkOutput("stall in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Enable drop of 3 cycles while in MUL_IM delays output by exactly 3
        applyStimulus(16'd7, 16'hFFF7, 17'd14, 32'd130, 1'b1);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("frozen out_valid", {63'd0, out_valid}, 64'd0);
        enable = 1'b1;
        waitValid(n);
        total = 1 + 3 + n;
        checkOutput("latency with freeze", 64'(total), 64'd6);
        @(posedge clk); #1;

        // Async reset during SUM drops the in-flight pair
        applyStimulus(16'd50, 16'd60, 17'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst det", {32'd0, det}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(16'd1, 16'd1, 17'd2, 32'd2, 1'b1);
        waitValid(n);
        checkOutput("latency after rst", 64'(n), 64'd3);
        repeat (3) @(posedge clk);
        #1;

        checkOutput("scoreboard drained", 64'(expTraceQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
